// File: rtl/regfile_mp_clr.sv
// regfile_mp_clr: multi-read-port register file with write bypass and a one-entry-per-cycle clear engine
module regfile_mp_clr #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AWIDTH-1:0]        waddr,
  input  logic [DWIDTH-1:0]        wdata,
  input  logic [NREAD*AWIDTH-1:0]  raddr,
  output logic [NREAD*DWIDTH-1:0]  rdata,
  input  logic                     clr,
  output logic                     init_busy
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0] DEP  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] LAST = (AWIDTH+1)'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;
  logic [AWIDTH:0] cnt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic w_ok, wr;
  always_ff @(posedge clk) state <= rst ? CLEAR : state_nxt;
  always_comb state_nxt = clr ? CLEAR : (state == CLEAR && cnt == LAST) ? RUN : state;
  always_comb init_busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + 1'b1;
  end
  assign w_ok = {1'b0, waddr} < DEP && !(ZERO_REG != 0 && waddr == '0);
  assign wr   = we && w_ok && state == RUN && !clr && !rst;
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt[IW-1:0]] <= '0;
    else if (wr) mem[waddr[IW-1:0]] <= wdata;
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AWIDTH-1:0] ra;
    assign ra = raddr[i*AWIDTH +: AWIDTH];
    assign rdata[i*DWIDTH +: DWIDTH] =
      (state != RUN || rst || {1'b0, ra} >= DEP || (ZERO_REG != 0 && ra == '0)) ? '0 :
      (BYPASS != 0 && wr && waddr == ra) ? wdata : mem[ra[IW-1:0]];
  end
endmodule

// File: tb/tb_regfile_mp_clr.sv
// tb_regfile_mp_clr: self-checking bench for regfile_mp_clr against a behavioural model
module tb_regfile_mp_clr;
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;
  logic clk = 1'b0;
  logic rst, clr, we;
  logic [4:0] waddr;
  logic [31:0] wdata;
  logic [9:0] raddr;
  logic [63:0] rdata;
  logic init_busy;
  logic [19:0] raddr2;
  logic [127:0] rdata2;
  logic init_busy2;
  logic [31:0] mm [2][32];
  int busy [2];
  int dep [2] = '{32, 16};
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv [9];
  logic [4:0] t6_a [5] = '{5'd1, 5'd2, 5'd3, 5'd15, 5'd20};
  logic [31:0] t6_d [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFF0000, 32'h20202020};
  always #5 clk = ~clk;
  regfile_mp_clr dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .clr(clr), .init_busy(init_busy)
  );
  regfile_mp_clr #(.NREAD(4), .DEPTH(16), .BYPASS(0)) dut2 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr2), .rdata(rdata2), .clr(clr), .init_busy(init_busy2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_rd(input int d, input logic [4:0] a);
    if (rst || busy[d] > 0 || int'(a) >= dep[d] || a == 5'd0) return '0;
    if (d == 0 && we && !clr && waddr == a) return wdata;
    return mm[d][a];
  endfunction
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst || clr) begin
        busy[d] = dep[d];
        for (int i = 0; i < 32; i++) mm[d][i] = '0;
      end else if (busy[d] > 0) busy[d]--;
      else if (we && int'(waddr) < dep[d] && waddr != 5'd0) mm[d][waddr] = wdata;
    end
  endtask
  task automatic check_all();
    chk("busy_a", {31'b0, init_busy}, {31'b0, busy[0] > 0});
    chk("busy_b", {31'b0, init_busy2}, {31'b0, busy[1] > 0});
    for (int p = 0; p < 2; p++) chk($sformatf("rd_a_p%0d", p), rdata[p*32 +: 32], ref_rd(0, raddr[p*5 +: 5]));
    for (int p = 0; p < 4; p++) chk($sformatf("rd_b_p%0d", p), rdata2[p*32 +: 32], ref_rd(1, raddr2[p*5 +: 5]));
  endtask
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic rnd_rd();
    raddr = 10'($urandom);
    raddr2 = 20'($urandom);
  endtask
  task automatic busy_len(input string name, input int want);
    int k = 0;
    while (init_busy === 1'b1 && k < 100) begin
      rnd_rd();
      tick();
      k++;
    end
    chk(name, k, want);
  endtask
  initial begin
    tv[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tv[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
    tv[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tv[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd6,  32'hA5A5A5A5, 32'h0,        32'h0};
    tv[5] = '{1'b1, 5'd3,  32'h55,       5'd7,  5'd3,  32'hA5A5A5A5, 32'h55,       32'hA5A5A5A5};
    tv[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd31, 32'h55,       32'h0,        32'h55};
    tv[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0,        32'h0};
    tv[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
    rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; raddr2 = '0;
    busy[0] = 32; busy[1] = 16;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tick();
    rst = 1'b0;
    busy_len("t1_busy_len", 32);
    for (int i = 0; i < 9; i++) begin
      we = tv[i].we; waddr = tv[i].wa; wdata = tv[i].wd;
      raddr = {tv[i].ra1, tv[i].ra0};
      raddr2 = {5'd15, 5'd3, 5'd2, tv[i].ra0};
      #2;
      chk($sformatf("tv%0d_busy", i), {31'b0, init_busy}, 32'h0);
      chk($sformatf("tv%0d_r0", i), rdata[31:0], tv[i].e0);
      chk($sformatf("tv%0d_r1", i), rdata[63:32], tv[i].e1);
      chk($sformatf("tv%0d_nobyp", i), rdata2[31:0], tv[i].e2);
      tick();
    end
    we = 1'b1; waddr = 5'd9; wdata = 32'h77; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_busy_next", {31'b0, init_busy}, 32'h1);
    busy_len("t4_busy_len", 32);
    we = 1'b0; raddr = {5'd9, 5'd3};
    #2;
    chk("t4_x3", rdata[31:0], 32'h0);
    chk("t4_x9", rdata[63:32], 32'h0);
    tick();
    we = 1'b1; waddr = 5'd4; wdata = 32'h44;
    tick();
    we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) begin rnd_rd(); tick(); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_len("t5_restart_len", 32);
    raddr = {5'd4, 5'd4};
    #2;
    chk("t5_x4", rdata[31:0], 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; waddr = t6_a[i]; wdata = t6_d[i]; rnd_rd();
      tick();
    end
    we = 1'b0; raddr2 = {5'd15, 5'd3, 5'd2, 5'd1}; raddr = {5'd20, 5'd15};
    #2;
    for (int p = 0; p < 4; p++) chk($sformatf("t6_p%0d", p), rdata2[p*32 +: 32], t6_d[p]);
    chk("t6_a_r20", rdata[63:32], 32'h20202020);
    tick();
    raddr2 = {4{5'd20}};
    #2;
    chk("t6_r20", rdata2[31:0], 32'h0);
    tick();
    for (int i = 0; i < 500; i++) begin
      rst = $urandom_range(0, 399) == 0;
      clr = $urandom_range(0, 149) == 0;
      we = $urandom_range(0, 2) != 0;
      waddr = 5'($urandom);
      wdata = $urandom;
      rnd_rd();
      if ($urandom_range(0, 2) == 0) raddr[4:0] = waddr;
      if ($urandom_range(0, 2) == 0) raddr2[9:5] = waddr;
      tick();
    end
    rst = 1'b0; clr = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
